demux_scheduler: RTL
====================

Name: demux_scheduler

Overview:
Packet-aware controller that steers one valid/ready input stream to one of N output channels. The destination is either taken from a per-packet dest field or chosen round-robin among enabled outputs. The selection is locked for the whole packet, from the first beat through the beat with s_last. A single output register stage decouples input and output timing; the block sits in front of the cell-library demux fabric and owns its select.

Parameters:
N, 5, number of output channels (2..16)
DW, 32, data width
DESTW, 3, width of s_dest; must satisfy 2**DESTW >= N

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_rr  input  1  1 = round-robin destination, 0 = use s_dest
cfg_en_mask  input  N  per-output enable; disabled outputs are never selected
s_valid  input  1  input beat valid
s_ready  output  1  input beat accepted when s_valid & s_ready
s_data  input  DW  input data
s_dest  input  DESTW  destination index, sampled on the first beat of a packet only
s_last  input  1  last beat of packet
m_valid  output  N  one-hot (or zero) output valid
m_ready  input  N  per-output ready
m_data  output  DW  shared output data bus, meaningful only where m_valid is set
m_last  output  1  last flag accompanying m_data
err_drop  output  1  one-cycle pulse on the first beat of a dropped packet

Behaviour:
- Reset (async assert, sync release). Cleared: m_valid=0, m_data=0, m_last=0, err_drop=0, rr_ptr=0, out_full=0. State resets to IDLE.
- s_ready is 0 while rst_n is low.
- FSM states:
  - IDLE (awaiting the first beat).
  - ROUTE (packet locked to cur_dest).
  - DROP (discarding the packet).
- IDLE, on an accepted beat:
  - Resolve the destination. With cfg_rr=1, dest = first enabled index at or after rr_ptr, wrapping modulo N. With cfg_rr=0, dest = s_dest.
  - If dest >= N, or cfg_en_mask[dest]=0, or cfg_rr=1 with mask all zero: pulse err_drop and go to DROP (or stay in IDLE if s_last).
  - Otherwise latch cur_dest, load the beat into the output register, and go to ROUTE (or stay in IDLE if s_last).
- ROUTE: each accepted beat goes to cur_dest. When s_last is accepted, return to IDLE.
- DROP: s_ready=1 and beats are consumed and discarded. When s_last is accepted, return to IDLE.
- Output register:
  - m_valid[cur_dest] = out_full; all other bits are 0.
  - In IDLE/ROUTE, s_ready = !out_full | m_ready[out_dest].
  - Throughput is 1 beat/cycle under continuous m_ready. Latency from input accept to m_valid is 1 cycle.
  - out_full clears on m_valid & m_ready when no new beat is loaded in the same cycle.
  - On simultaneous drain and load, the new beat replaces the old one with no bubble.
- Single-beat packet (s_valid & s_last in IDLE) is legal. State stays IDLE and no ROUTE cycle is inserted.
- Round-robin update: when a routed packet's s_last is accepted, rr_ptr becomes (dest+1) mod N. Dropped packets do not advance rr_ptr.
- Config timing: cfg_rr and cfg_en_mask are sampled only in IDLE on the first beat. Changes mid-packet take effect on the next packet. Clearing the enable of cur_dest mid-packet does not abort the packet.
- A new packet's first beat may be accepted while the previous packet's last beat sits in the output register, provided s_ready is high. The output register tracks its own out_dest, separate from cur_dest.
- Backpressure: if m_ready[out_dest]=0 indefinitely, s_ready stays 0 and the block never reorders or drops routed beats.

Optional Feature:
DEMUX_SCHED_STAT_EN:
- Defined: adds output stat_pkt_cnt [N*16]. Each 16-bit counter per output increments, saturating at 16'hFFFF, when a beat with m_last is taken (m_valid & m_ready & m_last). It also adds stat_drop_cnt [16], which increments saturating on each err_drop pulse. All counters are cleared by rst_n.
- Undefined: these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package demux_sched_pkg: state enum (IDLE, ROUTE, DROP), STAT_W=16, and a function checking dest legality.
- One sub-module, rr_pick: combinational first-set-at-or-after-pointer over an N-bit mask, outputting index and found flag. Used only for cfg_rr=1.

Test Plan:
1. cfg_rr=0, mask=5'b11111, 3-beat packets to s_dest=2 then 4, m_ready all 1 -> m_valid=5'b00100 for 3 cycles then 5'b10000 for 3. Each appears 1 cycle after accept; m_last on the 3rd beat of each.
2. cfg_rr=1, mask=5'b10110, four 1-beat packets -> destinations 1,2,4,1 in order.
3. cfg_rr=0, s_dest=6, 2-beat packet -> err_drop pulses once, s_ready=1 both beats, m_valid stays 0. The next packet to dest 0 routes normally and rr_ptr is unchanged.
4. Packet to dest 3 with m_ready[3]=0 for 10 cycles -> s_ready=0 and m_data holds beat 0. On release, beats follow 1 per cycle with no loss.
5. Clear mask bit 3 mid-packet -> current packet completes to 3. A next packet with s_dest=3 is dropped.
6. rst_n low mid-packet -> m_valid=0 immediately. After release, state is IDLE, the first beat is treated as packet start, and with DEMUX_SCHED_STAT_EN counters read 0.

Source files
------------

// File: rtl/demux_scheduler_pkg.sv
// Shared types and helpers for demux_scheduler.
package demux_sched_pkg;
  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  localparam int STAT_W = 16;

  function automatic logic dest_ok(input int unsigned dest, input logic [15:0] mask,
                                   input int unsigned n);
    return (dest < n) && mask[dest[3:0]];
  endfunction
endpackage

// File: rtl/demux_scheduler_if.sv
// Input stream plus N-way output stream bundle for demux_scheduler.
interface demux_scheduler_if #(parameter int N = 5, parameter int DW = 32, parameter int DESTW = 3);
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_data;
  logic [DESTW-1:0] s_dest;
  logic             s_last;
  logic [N-1:0]     m_valid;
  logic [N-1:0]     m_ready;
  logic [DW-1:0]    m_data;
  logic             m_last;

  modport master(output s_valid, s_data, s_dest, s_last, m_ready,
                 input  s_ready, m_valid, m_data, m_last);
  modport slave (input  s_valid, s_data, s_dest, s_last, m_ready,
                 output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/demux_scheduler_rr_pick.sv
// First set bit of mask at or after ptr, wrapping modulo N.
module rr_pick #(parameter int N = 5, parameter int DESTW = 3) (
  input  logic [N-1:0]     mask,
  input  logic [DESTW-1:0] ptr,
  output logic [DESTW-1:0] idx,
  output logic             found
);
  int j;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && mask[j]) begin
        found = 1'b1;
        idx   = DESTW'(j);
      end
    end
  end
endmodule

// File: rtl/demux_scheduler.sv
// Packet-locked 1:N stream steering with a single output register stage.
// Optional per-output packet / drop counters under DEMUX_SCHED_STAT_EN.
module demux_scheduler
  import demux_sched_pkg::*;
#(
  parameter int N     = 5,
  parameter int DW    = 32,
  parameter int DESTW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_rr,
  input  logic [N-1:0]   cfg_en_mask,
  demux_scheduler_if.slave bus,
  output logic           err_drop
`ifdef DEMUX_SCHED_STAT_EN
  ,
  output logic [N*STAT_W-1:0] stat_pkt_cnt,
  output logic [STAT_W-1:0]   stat_drop_cnt
`endif
);
  state_t           state_q, state_d;
  logic [DESTW-1:0] cur_dest, out_dest, rr_ptr, rr_idx, first_dest, beat_dest;
  logic             rr_found, first_ok, accept, load, drain, drop_start, rr_adv;
  logic             out_full, out_last, s_rdy;
  logic [DW-1:0]    out_data;
  logic [N-1:0]     m_vld;

  rr_pick #(.N(N), .DESTW(DESTW)) u_rr_pick (
    .mask (cfg_en_mask),
    .ptr  (rr_ptr),
    .idx  (rr_idx),
    .found(rr_found)
  );

  assign first_dest = cfg_rr ? rr_idx : bus.s_dest;
  assign first_ok   = cfg_rr ? rr_found : dest_ok(32'(bus.s_dest), 16'(cfg_en_mask), N);
  assign drain      = out_full & bus.m_ready[out_dest];

  always_comb begin
    s_rdy = 1'b0;
    if (rst_n) s_rdy = (state_q == DROP) ? 1'b1 : (!out_full | drain);
  end

  assign bus.s_ready = s_rdy;
  assign accept      = bus.s_valid & s_rdy;

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    drop_start = 1'b0;
    rr_adv     = 1'b0;
    beat_dest  = cur_dest;
    case (state_q)
      IDLE: begin
        beat_dest = first_dest;
        if (accept) begin
          if (first_ok) begin
            load   = 1'b1;
            rr_adv = bus.s_last;
            if (!bus.s_last) state_d = ROUTE;
          end else begin
            drop_start = 1'b1;
            if (!bus.s_last) state_d = DROP;
          end
        end
      end
      ROUTE: begin
        if (accept) begin
          load = 1'b1;
          if (bus.s_last) begin
            rr_adv  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DROP:    if (accept && bus.s_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_dest <= '0;
      rr_ptr   <= '0;
      err_drop <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_drop <= drop_start;
      if (state_q == IDLE && load) cur_dest <= first_dest;
      if (rr_adv) rr_ptr <= (beat_dest == DESTW'(N-1)) ? '0 : beat_dest + 1'b1;
    end
  end

  // A load in the same cycle as a drain overwrites the register: no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_full <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_dest <= '0;
    end else begin
      out_full <= load | (out_full & !drain);
      if (load) begin
        out_data <= bus.s_data;
        out_last <= bus.s_last;
        out_dest <= beat_dest;
      end
    end
  end

  always_comb begin
    m_vld = '0;
    if (out_full) m_vld[out_dest] = 1'b1;
  end

  assign bus.m_valid = m_vld;
  assign bus.m_data  = out_data;
  assign bus.m_last  = out_last;

`ifdef DEMUX_SCHED_STAT_EN
  logic [N-1:0][STAT_W-1:0] pkt_cnt;
  logic [STAT_W-1:0]        drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      for (int g = 0; g < N; g++)
        if (m_vld[g] && bus.m_ready[g] && out_last && pkt_cnt[g] != '1)
          pkt_cnt[g] <= pkt_cnt[g] + 1'b1;
      if (err_drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign stat_pkt_cnt  = pkt_cnt;
  assign stat_drop_cnt = drop_cnt;
`endif
endmodule
